// File: rtl/dsa_bil_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dsa_bil_pkg
// Brief    : Shared widths, FSM states and neighbourhood type for the
//            bilinear fetch controller.
// Revision : 1.0 - initial release
// ============================================================================
package dsa_bil_pkg;

    localparam int C_W_BITS = 6;
    localparam int C_H_BITS = 6;
    localparam int C_ADDR_W = 12;
    localparam int C_FRAC_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        A0   = 3'd1,
        A1   = 3'd2,
        A2   = 3'd3,
        A3   = 3'd4,
        CAP  = 3'd5,
        OUT  = 3'd6
    } fetch_state_t;

    typedef struct packed {
        logic [7:0]          p00;
        logic [7:0]          p01;
        logic [7:0]          p10;
        logic [7:0]          p11;
        logic [C_FRAC_W-1:0] fx;
        logic [C_FRAC_W-1:0] fy;
    } bil_nbhd_t;

    // A configured dimension of zero behaves as a one-pixel dimension.
    function automatic logic [31:0] dim_eff(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsa_bil_addr_calc.sv
`default_nettype none
// ============================================================================
// Module   : dsa_bil_addr_calc
// Brief    : Edge clamp and y*w+x RAM address for one of four neighbours.
// Revision : 1.0 - initial release
// ============================================================================
module dsa_bil_addr_calc
    import dsa_bil_pkg::*;
#(
    parameter int W_BITS = C_W_BITS,
    parameter int H_BITS = C_H_BITS,
    parameter int ADDR_W = C_ADDR_W
) (
    input  logic [W_BITS-1:0] x,
    input  logic [H_BITS-1:0] y,
    input  logic [W_BITS:0]   cfg_w,
    input  logic [H_BITS:0]   cfg_h,
    input  logic [1:0]        sel,
    output logic [ADDR_W-1:0] addr
);

    logic [W_BITS:0] w_w_eff;
    logic [H_BITS:0] w_h_eff;
    logic [W_BITS:0] w_x_max;
    logic [H_BITS:0] w_y_max;
    logic [W_BITS:0] w_xc;
    logic [H_BITS:0] w_yc;
    logic [W_BITS:0] w_x1;
    logic [H_BITS:0] w_y1;
    logic [W_BITS:0] w_xsel;
    logic [H_BITS:0] w_ysel;

    always_comb begin
        w_w_eff = (cfg_w == '0) ? (W_BITS+1)'(1) : cfg_w;
        w_h_eff = (cfg_h == '0) ? (H_BITS+1)'(1) : cfg_h;
        w_x_max = w_w_eff - (W_BITS+1)'(1);
        w_y_max = w_h_eff - (H_BITS+1)'(1);
        w_xc    = ({1'b0, x} < w_x_max) ? {1'b0, x} : w_x_max;
        w_yc    = ({1'b0, y} < w_y_max) ? {1'b0, y} : w_y_max;
        w_x1    = (w_xc == w_x_max) ? w_xc : w_xc + (W_BITS+1)'(1);
        w_y1    = (w_yc == w_y_max) ? w_yc : w_yc + (H_BITS+1)'(1);
        // sel bit 0 picks the right column, bit 1 the lower row.
        w_xsel  = sel[0] ? w_x1 : w_xc;
        w_ysel  = sel[1] ? w_y1 : w_yc;
        addr    = ADDR_W'(w_ysel) * ADDR_W'(w_w_eff) + ADDR_W'(w_xsel);
    end

endmodule
`default_nettype wire

// File: rtl/dsa_bil_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dsa_bil_fetch_ctrl
// Brief    : Fetches a clamped 2x2 pixel neighbourhood from image RAM and
//            hands it to the bilinear interpolator with valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module dsa_bil_fetch_ctrl
    import dsa_bil_pkg::*;
#(
    parameter int W_BITS = C_W_BITS,
    parameter int H_BITS = C_H_BITS,
    parameter int ADDR_W = C_ADDR_W,
    parameter int FRAC_W = C_FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_BITS:0]   cfg_w,
    input  logic [H_BITS:0]   cfg_h,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [W_BITS-1:0] req_x,
    input  logic [H_BITS-1:0] req_y,
    input  logic [FRAC_W-1:0] req_fx,
    input  logic [FRAC_W-1:0] req_fy,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [7:0]        mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_p00,
    output logic [7:0]        out_p01,
    output logic [7:0]        out_p10,
    output logic [7:0]        out_p11,
    output logic [FRAC_W-1:0] out_fx,
    output logic [FRAC_W-1:0] out_fy,
    output logic              busy,
    output logic [15:0]       fetch_count
);

    generate
        if (FRAC_W != C_FRAC_W || ADDR_W < W_BITS + H_BITS) begin : g_param_check
            $error("dsa_bil_fetch_ctrl: unsupported parameter combination");
        end
    endgenerate

    fetch_state_t      r_state;
    logic [W_BITS-1:0] r_x;
    logic [H_BITS-1:0] r_y;
    logic [W_BITS:0]   r_cfg_w;
    logic [H_BITS:0]   r_cfg_h;
    bil_nbhd_t         r_nbhd;
    logic              r_out_valid;
    logic [15:0]       r_fetch_count;
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_sel;
    logic              w_issue;

    dsa_bil_addr_calc #(
        .W_BITS (W_BITS),
        .H_BITS (H_BITS),
        .ADDR_W (ADDR_W)
    ) u_addr_calc (
        .x     (r_x),
        .y     (r_y),
        .cfg_w (r_cfg_w),
        .cfg_h (r_cfg_h),
        .sel   (w_sel),
        .addr  (w_addr)
    );

    always_comb begin
        w_sel   = 2'd0;
        w_issue = 1'b0;
        case (r_state)
            A0:      begin w_sel = 2'd0; w_issue = 1'b1; end
            A1:      begin w_sel = 2'd1; w_issue = 1'b1; end
            A2:      begin w_sel = 2'd2; w_issue = 1'b1; end
            A3:      begin w_sel = 2'd3; w_issue = 1'b1; end
            default: begin w_sel = 2'd0; w_issue = 1'b0; end
        endcase
    end

    // Address is live while issuing; otherwise the last issued address is held.
    assign mem_raddr   = w_issue ? w_addr : r_raddr;
    assign req_ready   = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign out_valid   = r_out_valid;
    assign out_p00     = r_nbhd.p00;
    assign out_p01     = r_nbhd.p01;
    assign out_p10     = r_nbhd.p10;
    assign out_p11     = r_nbhd.p11;
    assign out_fx      = r_nbhd.fx;
    assign out_fy      = r_nbhd.fy;
    assign fetch_count = r_fetch_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_cfg_w       <= '0;
            r_cfg_h       <= '0;
            r_nbhd        <= '0;
            r_out_valid   <= 1'b0;
            r_fetch_count <= 16'd0;
            r_raddr       <= '0;
        end else begin
            if (w_issue) begin
                r_raddr <= w_addr;
            end
            // Read data lags the address by one cycle, so each capture
            // happens in the state after its address was issued.
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_x       <= req_x;
                        r_y       <= req_y;
                        r_cfg_w   <= cfg_w;
                        r_cfg_h   <= cfg_h;
                        r_nbhd.fx <= req_fx;
                        r_nbhd.fy <= req_fy;
                        r_state   <= A0;
                    end
                end
                A0: r_state <= A1;
                A1: begin
                    r_nbhd.p00 <= mem_rdata;
                    r_state    <= A2;
                end
                A2: begin
                    r_nbhd.p01 <= mem_rdata;
                    r_state    <= A3;
                end
                A3: begin
                    r_nbhd.p10 <= mem_rdata;
                    r_state    <= CAP;
                end
                CAP: begin
                    r_nbhd.p11  <= mem_rdata;
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid   <= 1'b0;
                        r_fetch_count <= r_fetch_count + 16'd1;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    a_area_fits: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state != IDLE) |->
            (({32'd0, dim_eff(32'(r_cfg_w))} * {32'd0, dim_eff(32'(r_cfg_h))})
                <= (64'd1 << ADDR_W)));

endmodule
`default_nettype wire

// File: tb/tb_dsa_bil_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsa_bil_fetch_ctrl
// Brief    : Directed self-checking bench for dsa_bil_fetch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsa_bil_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [6:0]  cfg_w;
    logic [6:0]  cfg_h;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_x;
    logic [5:0]  req_y;
    logic [7:0]  req_fx;
    logic [7:0]  req_fy;
    logic [11:0] mem_raddr;
    logic [7:0]  mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_p00;
    logic [7:0]  out_p01;
    logic [7:0]  out_p10;
    logic [7:0]  out_p11;
    logic [7:0]  out_fx;
    logic [7:0]  out_fy;
    logic        busy;
    logic [15:0] fetch_count;

    int          checks;
    int          failures;
    logic [15:0] exp_cnt;
    logic [7:0]  mem [0:4095];

    dsa_bil_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_w       (cfg_w),
        .cfg_h       (cfg_h),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_fx      (req_fx),
        .req_fy      (req_fy),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_p00     (out_p00),
        .out_p01     (out_p01),
        .out_p10     (out_p10),
        .out_p11     (out_p11),
        .out_fx      (out_fx),
        .out_fy      (out_fy),
        .busy        (busy),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
    end

    always @(posedge clk) mem_rdata <= mem[mem_raddr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and records the four issued addresses and the
    // number of edges from accept until out_valid rises.
    task automatic fetch(input logic [5:0] x, input logic [5:0] y,
                         input logic [7:0] fx, input logic [7:0] fy,
                         input logic [6:0] w, input logic [6:0] h,
                         output logic [47:0] addrs, output int lat);
        cfg_w = w; cfg_h = h; req_x = x; req_y = y; req_fx = fx; req_fy = fy;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        cfg_w = 7'd5; cfg_h = 7'd3; req_x = 6'd17; req_y = 6'd9;
        req_fx = 8'hEE; req_fy = 8'hDD;
        addrs[47:36] = mem_raddr;
        for (int i = 1; i < 4; i++) begin
            step();
            addrs[47-12*i -: 12] = mem_raddr;
        end
        lat = 3;
        while (out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({out_valid, busy, fetch_count, mem_raddr} !== 30'd0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b busy=%b cnt=%h addr=%h required all 0",
                     out_valid, busy, fetch_count, mem_raddr);
        end
        checks++;
        if ({out_p00, out_p01, out_p10, out_p11, out_fx, out_fy} !== 48'd0) begin
            failures++;
            $display("FAIL reset_data: got %h%h%h%h fx=%h fy=%h required 0",
                     out_p00, out_p01, out_p10, out_p11, out_fx, out_fy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_req_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_basic();
        logic [47:0] a;
        int lat;
        fetch(6'd3, 6'd2, 8'h40, 8'h80, 7'd64, 7'd64, a, lat);
        checks++;
        if (a !== {12'd131, 12'd132, 12'd195, 12'd196}) begin
            failures++;
            $display("FAIL basic_addr: got %h required 083084 0c30c4 (131,132,195,196)", a);
        end
        checks++;
        if (lat !== 5) begin
            failures++;
            $display("FAIL basic_latency: got %0d edges required 5", lat);
        end
        checks++;
        if ({out_p00, out_p01, out_p10, out_p11} !== 32'h8384C3C4) begin
            failures++;
            $display("FAIL basic_pixels: got %h%h%h%h required 8384c3c4",
                     out_p00, out_p01, out_p10, out_p11);
        end
        checks++;
        if ({out_fx, out_fy} !== 16'h4080) begin
            failures++;
            $display("FAIL basic_frac: got fx=%h fy=%h required 40 80", out_fx, out_fy);
        end
        checks++;
        if (mem_raddr !== 12'd196 || req_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_out_state: got addr=%0d ready=%b busy=%b required 196 0 1",
                     mem_raddr, req_ready, busy);
        end
        consume();
        checks++;
        if (fetch_count !== exp_cnt || out_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_handshake: got cnt=%0d valid=%b ready=%b required %0d 0 1",
                     fetch_count, out_valid, req_ready, exp_cnt);
        end
    endtask

    task automatic test_clamp();
        logic [47:0] a;
        int lat;
        fetch(6'd63, 6'd63, 8'h01, 8'h02, 7'd64, 7'd64, a, lat);
        checks++;
        if (a !== {4{12'd4095}} || {out_p00, out_p01, out_p10, out_p11} !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL corner_clamp: got addr=%h pix=%h%h%h%h required all 4095 / ff",
                     a, out_p00, out_p01, out_p10, out_p11);
        end
        consume();
        fetch(6'd31, 6'd0, 8'h00, 8'h00, 7'd32, 7'd64, a, lat);
        checks++;
        if (a !== {12'd31, 12'd31, 12'd63, 12'd63} ||
            {out_p00, out_p01, out_p10, out_p11} !== 32'h1F1F3F3F) begin
            failures++;
            $display("FAIL right_edge: got addr=%h pix=%h%h%h%h required 31,31,63,63 / 1f1f3f3f",
                     a, out_p00, out_p01, out_p10, out_p11);
        end
        consume();
        fetch(6'd63, 6'd10, 8'h00, 8'h00, 7'd40, 7'd64, a, lat);
        checks++;
        if (a !== {12'd439, 12'd439, 12'd479, 12'd479} ||
            {out_p00, out_p01, out_p10, out_p11} !== 32'hB7B7DFDF) begin
            failures++;
            $display("FAIL range_clamp: got addr=%h pix=%h%h%h%h required 439,439,479,479 / b7b7dfdf",
                     a, out_p00, out_p01, out_p10, out_p11);
        end
        consume();
        fetch(6'd5, 6'd7, 8'h00, 8'h00, 7'd0, 7'd0, a, lat);
        checks++;
        if (a !== 48'd0 || lat !== 5) begin
            failures++;
            $display("FAIL zero_cfg: got addr=%h lat=%0d required 0 and 5", a, lat);
        end
        consume();
        checks++;
        if (fetch_count !== exp_cnt) begin
            failures++;
            $display("FAIL clamp_count: got %0d required %0d", fetch_count, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] a;
        int lat;
        fetch(6'd10, 6'd5, 8'h11, 8'h22, 7'd64, 7'd64, a, lat);
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({out_valid, req_ready, out_p00, out_p01, out_p10, out_p11, out_fx, out_fy}
                    !== {2'b10, 32'h4A4B8A8B, 16'h1122}) begin
                failures++;
                $display("FAIL backpressure_hold: cycle %0d got v=%b r=%b pix=%h%h%h%h fx=%h fy=%h required 1 0 4a4b8a8b 11 22",
                         i, out_valid, req_ready, out_p00, out_p01, out_p10, out_p11, out_fx, out_fy);
            end
        end
        consume();
        checks++;
        if (fetch_count !== exp_cnt || out_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: got cnt=%0d v=%b r=%b busy=%b required %0d 0 1 0",
                     fetch_count, out_valid, req_ready, busy, exp_cnt);
        end
        req_valid = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_no_accept: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [47:0] a;
        int lat;
        cfg_w = 7'd64; cfg_h = 7'd64; req_x = 6'd20; req_y = 6'd20;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #2;
        exp_cnt = 16'd0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || fetch_count !== 16'd0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL midop_reset: got v=%b busy=%b cnt=%0d ready=%b required 0 0 0 1",
                     out_valid, busy, fetch_count, req_ready);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        fetch(6'd0, 6'd0, 8'h00, 8'h00, 7'd64, 7'd64, a, lat);
        checks++;
        if (a !== {12'd0, 12'd1, 12'd64, 12'd65} ||
            {out_p00, out_p01, out_p10, out_p11} !== 32'h00014041) begin
            failures++;
            $display("FAIL midop_refetch: got addr=%h pix=%h%h%h%h required 0,1,64,65 / 00014041",
                     a, out_p00, out_p01, out_p10, out_p11);
        end
        consume();
        checks++;
        if (fetch_count !== 16'd1) begin
            failures++;
            $display("FAIL midop_count: got %0d required 1", fetch_count);
        end
    endtask

    initial begin
        checks = 0; failures = 0; exp_cnt = 16'd0;
        rst_n = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
        cfg_w = 7'd64; cfg_h = 7'd64; req_x = '0; req_y = '0; req_fx = '0; req_fy = '0;
        test_reset();
        test_basic();
        test_clamp();
        test_backpressure();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
